// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO write scheduler and its 512 x 8 storage array.
package fifo_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 9;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;

  // Pointers and occupancy both carry one extra bit: wrap flag / the value DEPTH itself.
  typedef logic [ADDR_WIDTH:0] ptr_t;
  typedef logic [ADDR_WIDTH:0] count_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, scanning circularly from the requester after the last grant.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IW-1:0] LAST_INIT = IW'(NUM_REQ - 1);

  logic [IW-1:0] r_last;
  logic [IW-1:0] w_sel;
  logic          w_hit;

  // Two passes: first requesters above the last grant, then wrap around to the rest.
  always_comb begin
    w_hit = 1'b0;
    w_sel = r_last;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_hit && req[i] && (IW'(i) > r_last)) begin
        w_hit = 1'b1;
        w_sel = IW'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_hit && req[i] && (IW'(i) <= r_last)) begin
        w_hit = 1'b1;
        w_sel = IW'(i);
      end
    end
    gnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt[i] = en && w_hit && (w_sel == IW'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= LAST_INIT;
    end else if (clr) begin
      r_last <= LAST_INIT;
    end else if (|gnt) begin
      r_last <= w_sel;
    end
  end
endmodule

// File: rtl/fifo_wr_sched.sv
// Write scheduler and pointer controller for the shared FIFO array: arbitrates producers onto
// the single write port, owns both pointers, occupancy, status and sticky error flags.
module fifo_wr_sched #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = fifo_pkg::ADDR_WIDTH,
  parameter int DEPTH      = fifo_pkg::DEPTH,
  parameter int AFULL_TH   = 496,
  parameter int AEMPTY_TH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          rd_req,
  output logic                          rd_ack,
  output logic                          w_en,
  output logic [DATA_WIDTH-1:0]         data_in,
  output logic [ADDR_WIDTH:0]           binary_wptr,
  output logic [ADDR_WIDTH:0]           binary_rptr,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [ADDR_WIDTH:0]           count,
  output logic                          ovf_err,
  output logic                          udf_err
);
  localparam int CW = ADDR_WIDTH + 1;

  if (DEPTH != (1 << ADDR_WIDTH)) begin : g_bad_depth
    $error("fifo_wr_sched: DEPTH must equal 2**ADDR_WIDTH");
  end

  logic [CW-1:0]      r_wptr, r_rptr, r_count, w_count_nxt;
  logic               r_afull, r_aempty, r_ovf, r_udf;
  logic               w_full, w_empty, w_wr, w_rd, w_arb_en;
  logic [NUM_REQ-1:0] w_gnt;

  // Status decodes from registered pointers only, so grant/ack never depend on this cycle's traffic.
  assign w_full  = (r_wptr[ADDR_WIDTH] != r_rptr[ADDR_WIDTH]) &&
                   (r_wptr[ADDR_WIDTH-1:0] == r_rptr[ADDR_WIDTH-1:0]);
  assign w_empty = (r_wptr == r_rptr);

  // Reset and flush both force the handshakes idle so nothing reaches the array.
  assign w_arb_en = rst_n && !flush && !w_full;
  assign w_rd     = rst_n && !flush && rd_req && !w_empty;
  assign w_wr     = |w_gnt;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .en    (w_arb_en),
    .req   (req),
    .gnt   (w_gnt)
  );

  always_comb begin
    data_in = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) data_in = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr && !w_rd)      w_count_nxt = r_count + CW'(1);
    else if (!w_wr && w_rd) w_count_nxt = r_count - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else if (flush) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + CW'(1);
      if (w_rd) r_rptr <= r_rptr + CW'(1);
      r_count  <= w_count_nxt;
      r_afull  <= (w_count_nxt >= CW'(AFULL_TH));
      r_aempty <= (w_count_nxt <= CW'(AEMPTY_TH));
      if (|req && w_full)    r_ovf <= 1'b1;
      if (rd_req && w_empty) r_udf <= 1'b1;
    end
  end

  assign gnt          = w_gnt;
  assign w_en         = w_wr;
  assign rd_ack       = w_rd;
  assign binary_wptr  = r_wptr;
  assign binary_rptr  = r_rptr;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;
  assign count        = r_count;
  assign ovf_err      = r_ovf;
  assign udf_err      = r_udf;
endmodule

// File: tb/tb_fifo_wr_sched.sv
// Bench for fifo_wr_sched: behavioural array, reference arbiter/occupancy model and data scoreboard.
module tb_fifo_wr_sched;
  localparam int NR    = 4;
  localparam int DW    = 8;
  localparam int AW    = 9;
  localparam int DEPTH = 512;

  logic             clk = 1'b0;
  logic             rst_n, flush, rd_req;
  logic [NR-1:0]    req;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    gnt;
  logic             rd_ack, w_en, full, empty, almost_full, almost_empty, ovf_err, udf_err;
  logic [DW-1:0]    data_in;
  logic [AW:0]      binary_wptr, binary_rptr, count;

  logic [DW-1:0] tb_mem [DEPTH];
  logic [DW-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int m_count, m_last, m_wptr, m_rptr;
  logic m_ovf, m_udf;

  fifo_wr_sched dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .req(req), .req_data(req_data), .gnt(gnt),
    .rd_req(rd_req), .rd_ack(rd_ack), .w_en(w_en), .data_in(data_in),
    .binary_wptr(binary_wptr), .binary_rptr(binary_rptr), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .ovf_err(ovf_err), .udf_err(udf_err)
  );

  always #5 clk = ~clk;

  // Stand-in for the storage array: synchronous write, combinational read.
  always @(posedge clk) if (w_en) tb_mem[binary_wptr[AW-1:0]] <= data_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_last = NR - 1; m_wptr = 0; m_rptr = 0;
    m_ovf = 1'b0; m_udf = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_regs();
    check("count", count, m_count);
    check("wptr", binary_wptr, m_wptr);
    check("rptr", binary_rptr, m_rptr);
    check("full", full, m_count == DEPTH);
    check("empty", empty, m_count == 0);
    check("almost_full", almost_full, m_count >= 496);
    check("almost_empty", almost_empty, m_count <= 16);
    check("ovf_err", ovf_err, m_ovf);
    check("udf_err", udf_err, m_udf);
  endtask

  task automatic cycle(input logic [NR-1:0] rq, input logic rd, input logic fl);
    int gi, idx;
    logic [NR-1:0] eg;
    logic ea;
    logic [DW-1:0] ed, rdata;
    @(negedge clk);
    req = rq; rd_req = rd; flush = fl; req_data = $urandom;
    #1;
    gi = -1;
    eg = '0;
    if (!fl && m_count != DEPTH) begin
      for (int k = 1; k <= NR; k++) begin
        idx = (m_last + k) % NR;
        if (gi < 0 && rq[idx]) gi = idx;
      end
    end
    if (gi >= 0) eg[gi] = 1'b1;
    ea = rd && !fl && (m_count != 0);
    ed = (gi >= 0) ? req_data[gi*DW +: DW] : '0;
    check("gnt", gnt, eg);
    check("w_en", w_en, gi >= 0);
    check("data_in", data_in, ed);
    check("rd_ack", rd_ack, ea);
    if (gi >= 0) exp_q.push_back(ed);
    if (ea) begin
      rdata = tb_mem[binary_rptr[AW-1:0]];
      check("sb_nonempty", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) check("rd_data", rdata, exp_q.pop_front());
    end
    if (fl) begin
      model_reset();
    end else begin
      if (|rq && m_count == DEPTH) m_ovf = 1'b1;
      if (rd && m_count == 0) m_udf = 1'b1;
      if (gi >= 0) begin
        m_wptr = (m_wptr + 1) % (2 * DEPTH);
        m_last = gi;
      end
      if (ea) m_rptr = (m_rptr + 1) % (2 * DEPTH);
      if (gi >= 0 && !ea) m_count++;
      else if (gi < 0 && ea) m_count--;
    end
    @(posedge clk);
    #1;
    check_regs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; req = '0; rd_req = 1'b0; req_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_regs();
    check("gnt_reset", gnt, 0);
    check("rd_ack_reset", rd_ack, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill with all requesters active, then push past full.
    repeat (520) cycle(4'b1111, 1'b0, 1'b0);
    check("full_after_fill", full, 1'b1);
    check("ovf_after_fill", ovf_err, 1'b1);

    // Full: read wins, write blocked.
    cycle(4'b0100, 1'b1, 1'b0);
    check("count_full_rw", count, 511);

    // Drain everything and read past empty.
    repeat (514) cycle(4'b0000, 1'b1, 1'b0);
    check("rptr_wrap", binary_rptr, 10'h200);
    check("empty_drained", empty, 1'b1);
    check("udf_after_drain", udf_err, 1'b1);

    // Empty: write wins, read blocked.
    cycle(4'b0100, 1'b1, 1'b0);
    check("count_empty_rw", count, 1);
    cycle(4'b0000, 1'b1, 1'b0);

    // Two requesters alternate, then one drops out.
    repeat (6) cycle(4'b1010, 1'b1, 1'b0);
    repeat (4) cycle(4'b0010, 1'b1, 1'b0);

    // Flush with competing traffic.
    cycle(4'b1111, 1'b1, 1'b1);
    check("ovf_flushed", ovf_err, 1'b0);
    check("count_flushed", count, 0);

    // Thresholds.
    repeat (496) cycle(4'b1111, 1'b0, 1'b0);
    check("afull_at_496", almost_full, 1'b1);
    repeat (480) cycle(4'b0000, 1'b1, 1'b0);
    check("aempty_at_16", almost_empty, 1'b1);

    // Random traffic.
    repeat (400) cycle(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);

    // Asynchronous reset mid-cycle at count 100.
    cycle(4'b0000, 1'b0, 1'b1);
    repeat (100) cycle(4'b1111, 1'b0, 1'b0);
    check("count_pre_reset", count, 100);
    @(negedge clk);
    req = 4'b1111; rd_req = 1'b1; flush = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_regs();
    check("gnt_async_rst", gnt, 0);
    check("w_en_async_rst", w_en, 1'b0);
    check("rd_ack_async_rst", rd_ack, 1'b0);
    check("data_in_async_rst", data_in, 0);
    @(posedge clk);
    #1;
    check_regs();
    @(negedge clk);
    rst_n = 1'b1; req = '0; rd_req = 1'b0;
    cycle(4'b1000, 1'b0, 1'b0);
    cycle(4'b0011, 1'b1, 1'b0);
    cycle(4'b0011, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
